// File: rtl/imem_arbiter_if.sv
// Instruction-memory arbiter bus: two requesters, one memory, grant counters.
// slave = arbiter side, master = requesters/memory side.
interface imem_arbiter_if #(
  parameter int AW    = 30,
  parameter int DW    = 32,
  parameter int CNT_W = 16
);
  logic          req0;
  logic [AW-1:0] addr0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic [AW-1:0] addr1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_inst;

  logic [CNT_W-1:0] gcnt0;
  logic [CNT_W-1:0] gcnt1;

  modport slave (
    input  req0, addr0, req1, addr1,
    input  mem_inst,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_addr,
    output gcnt0, gcnt1
  );

  modport master (
    output req0, addr0, req1, addr1,
    output mem_inst,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_addr,
    input  gcnt0, gcnt1
  );
endinterface

// File: rtl/imem_arbiter.sv
// Two-port arbiter for a synchronous-read instruction memory.
// Round-robin or fixed priority with a starvation guard on port 1.
module imem_arbiter #(
  parameter int AW         = 30,
  parameter int DW         = 32,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_WAIT   = 4,
  parameter int CNT_W      = 16
) (
  input logic           clk,
  input logic           rst,
  imem_arbiter_if.slave bus
);

  typedef enum logic {
    LAST_P0 = 1'b0,
    LAST_P1 = 1'b1
  } last_e;

  localparam logic [7:0] WMAX = 8'(MAX_WAIT);
  localparam bit         FIX  = (FIXED_PRIO != 0);

  last_e            last_q, last_d;
  logic [7:0]       wait_q, wait_d;
  logic [AW-1:0]    held_q, held_d;
  logic [CNT_W-1:0] gc0_q, gc0_d;
  logic [CNT_W-1:0] gc1_q, gc1_d;
  logic             rv0_q, rv1_q;
  logic             g0, g1;
  logic             force1;

  assign force1 = FIX && bus.req1 && (wait_q == WMAX);

  // Grants are suppressed while rst is high.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      if (FIX) begin
        if (force1) begin
          g1 = 1'b1;
        end else if (bus.req0) begin
          g0 = 1'b1;
        end else begin
          g1 = bus.req1;
        end
      end else if (bus.req0 && bus.req1) begin
        g0 = (last_q == LAST_P1);
        g1 = (last_q == LAST_P0);
      end else begin
        g0 = bus.req0;
        g1 = bus.req1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    held_d = held_q;
    gc0_d  = gc0_q;
    gc1_d  = gc1_q;
    wait_d = '0;
    if (g0) begin
      last_d = LAST_P0;
      held_d = bus.addr0;
      gc0_d  = gc0_q + CNT_W'(1);
    end
    if (g1) begin
      last_d = LAST_P1;
      held_d = bus.addr1;
      gc1_d  = gc1_q + CNT_W'(1);
    end
    if (FIX && bus.req1 && !g1) begin
      wait_d = (wait_q == WMAX) ? wait_q
                                : wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= LAST_P1;
      wait_q <= '0;
      held_q <= '0;
      gc0_q  <= '0;
      gc1_q  <= '0;
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      wait_q <= wait_d;
      held_q <= held_d;
      gc0_q  <= gc0_d;
      gc1_q  <= gc1_d;
      rv0_q  <= g0;
      rv1_q  <= g1;
    end
  end

  // Idle cycles replay the held address so mem_inst stays stable.
  assign bus.mem_addr = g0 ? bus.addr0
                      : g1 ? bus.addr1
                      : held_q;

  assign bus.gnt0    = g0;
  assign bus.gnt1    = g1;
  assign bus.rvalid0 = rv0_q;
  assign bus.rvalid1 = rv1_q;
  assign bus.rdata0  = rv0_q ? bus.mem_inst : '0;
  assign bus.rdata1  = rv1_q ? bus.mem_inst : '0;
  assign bus.gcnt0   = gc0_q;
  assign bus.gcnt1   = gc1_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: round-robin, fixed-priority and 4-bit-counter
// instances; read data checked through per-port expected-data queues.
module tb_imem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [31:0] mem [16];
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  imem_arbiter_if #(.AW(30), .DW(32), .CNT_W(16)) rr();
  imem_arbiter_if #(.AW(30), .DW(32), .CNT_W(16)) fx();
  imem_arbiter_if #(.AW(30), .DW(32), .CNT_W(4))  c4();

  imem_arbiter #(
    .AW(30), .DW(32), .FIXED_PRIO(0), .MAX_WAIT(4), .CNT_W(16)
  ) u_rr (.clk(clk), .rst(rst), .bus(rr));

  imem_arbiter #(
    .AW(30), .DW(32), .FIXED_PRIO(1), .MAX_WAIT(4), .CNT_W(16)
  ) u_fx (.clk(clk), .rst(rst), .bus(fx));

  imem_arbiter #(
    .AW(30), .DW(32), .FIXED_PRIO(0), .MAX_WAIT(4), .CNT_W(4)
  ) u_c4 (.clk(clk), .rst(rst), .bus(c4));

  logic [29:0] rr_ma_q = '0;
  always @(posedge clk) rr_ma_q <= rr.mem_addr;
  assign rr.mem_inst = mem[rr_ma_q[3:0]];
  assign fx.mem_inst = 32'h0;
  assign c4.mem_inst = 32'h0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Monitor: every rvalid pops one expected word.
  always begin
    @(posedge clk);
    #2;
    if (rr.rvalid0) begin
      if (q0.size() == 0) chk("rvalid0_unexpected", 1, 0);
      else chk("rdata0", rr.rdata0, q0.pop_front());
    end
    if (rr.rvalid1) begin
      if (q1.size() == 0) chk("rvalid1_unexpected", 1, 0);
      else chk("rdata1", rr.rdata1, q1.pop_front());
    end
  end

  task automatic rr_cyc(input logic r0, input logic [29:0] a0,
                        input logic r1, input logic [29:0] a1,
                        input logic eg0, input logic eg1,
                        input logic [29:0] ema, input string tag);
    @(negedge clk);
    rr.req0  = r0;
    rr.addr0 = a0;
    rr.req1  = r1;
    rr.addr1 = a1;
    #1;
    chk({tag, "_gnt0"}, rr.gnt0, eg0);
    chk({tag, "_gnt1"}, rr.gnt1, eg1);
    chk({tag, "_maddr"}, rr.mem_addr, ema);
    if (eg0) q0.push_back(mem[a0[3:0]]);
    if (eg1) q1.push_back(mem[a1[3:0]]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rr.req0 = 0; rr.req1 = 0;
    fx.req0 = 0; fx.req1 = 0;
    c4.req0 = 0; c4.req1 = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [9:0] fexp;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = {16'hC0DE, 16'(i)};
    mem[0] = 32'h2417_0000;
    mem[3] = 32'h1510_0003;
    rr.req0 = 1; rr.addr0 = 0; rr.req1 = 1; rr.addr1 = 0;
    fx.req0 = 0; fx.addr0 = 0; fx.req1 = 0; fx.addr1 = 0;
    c4.req0 = 0; c4.addr0 = 0; c4.req1 = 0; c4.addr1 = 0;

    #3;
    chk("rst_gnt0", rr.gnt0, 0);
    chk("rst_gnt1", rr.gnt1, 0);
    chk("rst_rvalid0", rr.rvalid0, 0);
    chk("rst_rvalid1", rr.rvalid1, 0);
    chk("rst_gcnt0", rr.gcnt0, 0);
    chk("rst_gcnt1", rr.gcnt1, 0);
    chk("rst_maddr", rr.mem_addr, 0);
    @(negedge clk);
    rr.req0 = 0; rr.req1 = 0;
    rst = 1'b0;

    rr_cyc(1, 0, 0, 0, 1, 0, 0, "sp0");
    rr_cyc(1, 3, 0, 0, 1, 0, 3, "sp1");
    rr_cyc(0, 0, 0, 0, 0, 0, 3, "sp_idle");
    chk("sp_gcnt0", rr.gcnt0, 2);

    do_reset();
    rr_cyc(1, 1, 1, 2, 1, 0, 1, "rr0");
    rr_cyc(1, 1, 1, 2, 0, 1, 2, "rr1");
    rr_cyc(1, 1, 1, 2, 1, 0, 1, "rr2");
    rr_cyc(1, 1, 1, 2, 0, 1, 2, "rr3");
    rr_cyc(0, 0, 0, 0, 0, 0, 2, "rr_idle");
    chk("rr_gcnt0", rr.gcnt0, 2);
    chk("rr_gcnt1", rr.gcnt1, 2);

    rr_cyc(0, 0, 1, 5, 0, 1, 5, "hold_g");
    rr_cyc(0, 0, 0, 0, 0, 0, 5, "hold1");
    rr_cyc(0, 0, 0, 0, 0, 0, 5, "hold2");
    chk("hold2_rvalid1", rr.rvalid1, 0);
    rr_cyc(0, 0, 0, 0, 0, 0, 5, "hold3");
    chk("hold3_rvalid1", rr.rvalid1, 0);

    @(negedge clk);
    rr.req0 = 1; rr.addr0 = 3;
    #1;
    chk("mid_gnt0_pre", rr.gnt0, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_gnt0_rst", rr.gnt0, 0);
    chk("mid_maddr", rr.mem_addr, 0);
    chk("mid_gcnt0", rr.gcnt0, 0);
    @(posedge clk);
    #2;
    chk("mid_rvalid0", rr.rvalid0, 0);
    @(negedge clk);
    rst = 1'b0;
    rr.req0 = 1; rr.addr0 = 1;
    rr.req1 = 1; rr.addr1 = 2;
    #1;
    chk("post_gnt0", rr.gnt0, 1);
    chk("post_gnt1", rr.gnt1, 0);
    q0.push_back(mem[1]);
    #3;
    chk("post_rvalid0", rr.rvalid0, 0);
    rr_cyc(1, 1, 1, 2, 0, 1, 2, "post1");
    rr_cyc(0, 0, 0, 0, 0, 0, 2, "post_idle");

    do_reset();
    fexp = 10'b10_0001_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      fx.req0 = 1; fx.addr0 = 8;
      fx.req1 = 1; fx.addr1 = 9;
      #1;
      chk($sformatf("fx%0d_gnt1", i), fx.gnt1, fexp[i]);
      chk($sformatf("fx%0d_gnt0", i), fx.gnt0, !fexp[i]);
      chk($sformatf("fx%0d_maddr", i), fx.mem_addr,
          fexp[i] ? 9 : 8);
    end
    @(negedge clk);
    fx.req0 = 0; fx.req1 = 0;
    #1;
    chk("fx_gcnt0", fx.gcnt0, 8);
    chk("fx_gcnt1", fx.gcnt1, 2);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      c4.req0 = 1; c4.addr0 = 30'(i);
      #1;
      if (i == 15) chk("c4_gcnt0_15", c4.gcnt0, 15);
      if (i == 16) chk("c4_gcnt0_wrap", c4.gcnt0, 0);
    end
    @(negedge clk);
    c4.req0 = 0;
    #1;
    chk("c4_gcnt0_17", c4.gcnt0, 1);

    repeat (2) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
